instruction_sequencer: RTL and testbench

- Fetch/decode/control stage directly upstream of the 4-bit accumulator/register datapath.
- Runs the 8-phase instruction cycle A1 A2 A3 M1 M2 X1 X2 X3:
  - drives the 12-bit program counter out over a 4-bit bus as three nibbles;
  - reads the 8-bit instruction back as two nibbles;
  - issues one-clock datapath control strobes in X3.
- Owns the PC and two-word (jump) instruction handling.

---
 rtl/instruction_sequencer_pkg.sv | 45 ++++
 rtl/instruction_sequencer_inst_decoder.sv | 55 +++++
 rtl/instruction_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_instruction_sequencer.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/instruction_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// instruction_sequencer_pkg
// Shared definitions for the instruction sequencer:
//   phase_t  - 8-phase instruction cycle encoding (A1 A2 A3 M1 M2 X1 X2 X3)
//   OPR_* / OPA_* - opcode nibbles recognised by the decoder
//   ctrl_t   - bundle of datapath strobes/selects issued in X3
// -----------------------------------------------------------------------------
package instruction_sequencer_pkg;

    typedef enum logic [2:0] {
        PH_A1 = 3'd0,
        PH_A2 = 3'd1,
        PH_A3 = 3'd2,
        PH_M1 = 3'd3,
        PH_M2 = 3'd4,
        PH_X1 = 3'd5,
        PH_X2 = 3'd6,
        PH_X3 = 3'd7
    } phase_t;

    localparam logic [3:0] OPR_LDM   = 4'hD;
    localparam logic [3:0] OPR_LD    = 4'hA;
    localparam logic [3:0] OPR_XCH   = 4'hB;
    localparam logic [3:0] OPR_JUN   = 4'h4;
    localparam logic [3:0] OPR_GRP_F = 4'hF;
    localparam logic [3:0] OPA_CLB   = 4'h0;
    localparam logic [3:0] OPA_CLC   = 4'h1;

    typedef struct packed {
        logic clear_carry;
        logic clear_accumulator;
        logic write_accumulator;
        logic acc_input_sel;
        logic write_register;
        logic reg_input_sel;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

    // First word of a two-word jump: only when not already consuming a second word.
    function automatic logic is_jun_first(input logic [3:0] opr, input logic jump_pending);
        return (!jump_pending) && (opr == OPR_JUN);
    endfunction

endpackage

// File: rtl/instruction_sequencer_inst_decoder.sv
// -----------------------------------------------------------------------------
// inst_decoder
// Purely combinational decode of the fetched instruction into datapath
// strobes/selects. The sequencer registers the result so it appears only in X3.
// Ports:
//   opr          in  4  upper instruction nibble
//   opa          in  4  lower instruction nibble
//   jump_pending in  1  current fetch is the second word of JUN (not decoded)
//   ctrl         out    strobe/select bundle (ctrl_t)
//   operand      out 4  OPA nibble passed to the datapath
// -----------------------------------------------------------------------------
module inst_decoder
    import instruction_sequencer_pkg::*;
(
    input  logic [3:0] opr,
    input  logic [3:0] opa,
    input  logic       jump_pending,
    output ctrl_t      ctrl,
    output logic [3:0] operand
);

    assign operand = opa;

    always_comb begin
        ctrl = CTRL_IDLE;
        if (!jump_pending) begin
            unique case (opr)
                OPR_LDM: begin
                    ctrl.write_accumulator = 1'b1;
                end
                OPR_LD: begin
                    ctrl.write_accumulator = 1'b1;
                    ctrl.acc_input_sel     = 1'b1;
                end
                OPR_XCH: begin
                    // Accumulator and register r swap on the same edge.
                    ctrl.write_accumulator = 1'b1;
                    ctrl.acc_input_sel     = 1'b1;
                    ctrl.write_register    = 1'b1;
                    ctrl.reg_input_sel     = 1'b0;
                end
                OPR_GRP_F: begin
                    if (opa == OPA_CLB) begin
                        ctrl.clear_accumulator = 1'b1;
                        ctrl.clear_carry       = 1'b1;
                    end else if (opa == OPA_CLC) begin
                        ctrl.clear_carry = 1'b1;
                    end
                end
                default: ctrl = CTRL_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/instruction_sequencer.sv
// -----------------------------------------------------------------------------
// instruction_sequencer
// Fetch/decode/control stage for the 4-bit accumulator datapath. Runs the
// 8-phase cycle A1 A2 A3 M1 M2 X1 X2 X3: sends the 12-bit PC out as three
// nibbles, reads the 8-bit instruction back as two nibbles, and issues
// one-clock control strobes in X3. Handles two-word JUN.
//
// Optional build macro: INSTRUCTION_SEQUENCER_SINGLE_STEP_EN
//   adds step_mode/step inputs; with step_mode=1 the FSM holds in A1 until step=1.
//
// Ports:
//   clock, reset            clock and synchronous active-high reset
//   step_mode, step         (macro only) single-step control
//   data_in           in 4  instruction nibble, sampled in M1 (opr) and M2 (opa)
//   data_out          out 4 address nibble in A1/A2/A3, else 0
//   data_out_en       out 1 high in A1..A3
//   sync              out 1 high in X3
//   clear_carry, clear_accumulator, write_accumulator, write_register  strobes
//   inst_operand      out 4 OPA of current instruction
//   acc_input_sel     out 1 1 = accumulator from registers[operand]
//   reg_input_sel     out 1 register source select (always 0)
//
// state | meaning
// A1    | drive pc[3:0]
// A2    | drive pc[7:4]
// A3    | drive pc[11:8]
// M1    | latch opr
// M2    | latch opa, pc += 1
// X1    | execute wait
// X2    | execute wait, decode registered into X3
// X3    | strobes out; JUN bookkeeping / pc load
// -----------------------------------------------------------------------------
module instruction_sequencer
    import instruction_sequencer_pkg::*;
#(
    parameter logic [11:0] PC_RESET = 12'h000
)
(
    input  logic       clock,
    input  logic       reset,
`ifdef INSTRUCTION_SEQUENCER_SINGLE_STEP_EN
    input  logic       step_mode,
    input  logic       step,
`endif
    input  logic [3:0] data_in,
    output logic [3:0] data_out,
    output logic       data_out_en,
    output logic       sync,
    output logic       clear_carry,
    output logic       clear_accumulator,
    output logic       write_accumulator,
    output logic [3:0] inst_operand,
    output logic       acc_input_sel,
    output logic       write_register,
    output logic       reg_input_sel
);

    phase_t      phase;
    phase_t      phase_next;
    logic [11:0] pc;
    logic [11:0] pc_next;
    logic [3:0]  opr;
    logic [3:0]  opa;
    logic        jump_pending;
    logic [3:0]  jump_hi;
    logic        a1_advance;
    logic        addr_en_next;
    logic [3:0]  addr_nib_next;
    ctrl_t       ctrl_dec;
    ctrl_t       ctrl_q;
    logic [3:0]  dec_operand;

`ifdef INSTRUCTION_SEQUENCER_SINGLE_STEP_EN
    assign a1_advance = !step_mode || step;
`else
    assign a1_advance = 1'b1;
`endif

    inst_decoder u_inst_decoder (
        .opr          (opr),
        .opa          (opa),
        .jump_pending (jump_pending),
        .ctrl         (ctrl_dec),
        .operand      (dec_operand)
    );

    always_comb begin
        phase_next = phase;
        unique case (phase)
            PH_A1:   phase_next = a1_advance ? PH_A2 : PH_A1;
            PH_A2:   phase_next = PH_A3;
            PH_A3:   phase_next = PH_M1;
            PH_M1:   phase_next = PH_M2;
            PH_M2:   phase_next = PH_X1;
            PH_X1:   phase_next = PH_X2;
            PH_X2:   phase_next = PH_X3;
            PH_X3:   phase_next = PH_A1;
            default: phase_next = PH_A1;
        endcase
    end

    always_comb begin
        pc_next = pc;
        if (phase == PH_M2) begin
            pc_next = pc + 12'd1;
        end else if ((phase == PH_X3) && jump_pending) begin
            pc_next = {jump_hi, opr, opa};
        end
    end

    // Address outputs are registered from the next phase and next pc so a jump
    // target loaded at the end of X3 is already on the bus in the following A1.
    always_comb begin
        addr_en_next  = 1'b0;
        addr_nib_next = 4'h0;
        unique case (phase_next)
            PH_A1: begin
                addr_en_next  = 1'b1;
                addr_nib_next = pc_next[3:0];
            end
            PH_A2: begin
                addr_en_next  = 1'b1;
                addr_nib_next = pc_next[7:4];
            end
            PH_A3: begin
                addr_en_next  = 1'b1;
                addr_nib_next = pc_next[11:8];
            end
            default: begin
                addr_en_next  = 1'b0;
                addr_nib_next = 4'h0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            phase        <= PH_A1;
            pc           <= PC_RESET;
            opr          <= 4'h0;
            opa          <= 4'h0;
            jump_pending <= 1'b0;
            jump_hi      <= 4'h0;
            data_out     <= 4'h0;
            data_out_en  <= 1'b0;
            sync         <= 1'b0;
            ctrl_q       <= CTRL_IDLE;
        end else begin
            phase <= phase_next;
            pc    <= pc_next;
            if (phase == PH_M1) begin
                opr <= data_in;
            end
            if (phase == PH_M2) begin
                opa <= data_in;
            end
            if (phase == PH_X3) begin
                if (jump_pending) begin
                    jump_pending <= 1'b0;
                end else if (is_jun_first(opr, jump_pending)) begin
                    jump_pending <= 1'b1;
                    jump_hi      <= opa;
                end
            end
            data_out    <= addr_nib_next;
            data_out_en <= addr_en_next;
            sync        <= (phase_next == PH_X3);
            ctrl_q      <= (phase_next == PH_X3) ? ctrl_dec : CTRL_IDLE;
        end
    end

    assign clear_carry       = ctrl_q.clear_carry;
    assign clear_accumulator = ctrl_q.clear_accumulator;
    assign write_accumulator = ctrl_q.write_accumulator;
    assign acc_input_sel     = ctrl_q.acc_input_sel;
    assign write_register    = ctrl_q.write_register;
    assign reg_input_sel     = ctrl_q.reg_input_sel;
    assign inst_operand      = dec_operand;

endmodule

// File: tb/tb_instruction_sequencer.sv
module tb_instruction_sequencer;

    logic       clock;
    logic       reset;
    logic [3:0] data_in;
    logic [3:0] data_out;
    logic       data_out_en;
    logic       sync;
    logic       clear_carry;
    logic       clear_accumulator;
    logic       write_accumulator;
    logic [3:0] inst_operand;
    logic       acc_input_sel;
    logic       write_register;
    logic       reg_input_sel;
    logic [5:0] strobes;

    assign strobes = {clear_carry, clear_accumulator, write_accumulator,
                      acc_input_sel, write_register, reg_input_sel};

    instruction_sequencer #(.PC_RESET(12'h000)) dut (
        .clock             (clock),
        .reset             (reset),
        .data_in           (data_in),
        .data_out          (data_out),
        .data_out_en       (data_out_en),
        .sync              (sync),
        .clear_carry       (clear_carry),
        .clear_accumulator (clear_accumulator),
        .write_accumulator (write_accumulator),
        .inst_operand      (inst_operand),
        .acc_input_sel     (acc_input_sel),
        .write_register    (write_register),
        .reg_input_sel     (reg_input_sel)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [11:0] addr;
        logic [5:0]  st;
        logic [3:0]  op;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;
    logic done = 1'b0;

    logic [2:0] tb_phase = 3'd0;
    logic       skip_en  = 1'b1;

    // Reference phase counter: the default build advances every clock.
    always @(posedge clock) begin
        if (reset) begin
            tb_phase <= 3'd0;
            skip_en  <= 1'b1;
        end else begin
            tb_phase <= tb_phase + 3'd1;
            if (tb_phase == 3'd7) skip_en <= 1'b0;
        end
    end

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    logic [3:0] cap [3];
    logic       idle_bad = 1'b0;
    logic       en_bad   = 1'b0;
    exp_t       e;

    always @(negedge clock) begin
        if (reset) begin
            check("reset_data_out", 32'(data_out), 32'h0);
            check("reset_data_out_en", 32'(data_out_en), 32'h0);
            check("reset_sync", 32'(sync), 32'h0);
            check("reset_strobes", 32'(strobes), 32'h0);
            check("reset_operand", 32'(inst_operand), 32'h0);
            idle_bad = 1'b0;
            en_bad   = 1'b0;
        end else if (done) begin
            check("scoreboard_drained", 32'(sb.size()), 32'h0);
            $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
            $finish;
        end else begin
            if (tb_phase == 3'd0) begin
                idle_bad = 1'b0;
                en_bad   = 1'b0;
            end
            if (tb_phase <= 3'd2) begin
                cap[int'(tb_phase)] = data_out;
                if (!(skip_en && tb_phase == 3'd0) && !data_out_en) en_bad = 1'b1;
            end else if (data_out_en || data_out != 4'h0) begin
                en_bad = 1'b1;
            end
            if (!sync && strobes != 6'h0) idle_bad = 1'b1;
            if (sync) begin
                check("sync_phase", 32'(tb_phase), 32'd7);
                if (sb.size() == 0) begin
                    check("unexpected_sync", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("fetch_addr", 32'({cap[2], cap[1], cap[0]}), 32'(e.addr));
                    check("x3_strobes", 32'(strobes), 32'(e.st));
                    check("x3_operand", 32'(inst_operand), 32'(e.op));
                    check("strobe_outside_x3", 32'(idle_bad), 32'd0);
                    check("addr_bus_enable", 32'(en_bad), 32'd0);
                end
            end
        end
    end

    // Entered at the negedge inside A1; returns at the negedge inside the next A1.
    task automatic run_cycle(input logic [11:0] addr, input logic [7:0] inst,
                             input logic [5:0] st, input logic [3:0] op);
        exp_t x;
        x.addr = addr;
        x.st   = st;
        x.op   = op;
        sb.push_back(x);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            if (k == 3) data_in = inst[7:4];
            if (k == 4) data_in = inst[3:0];
        end
    endtask

    // Starts an instruction, then asserts reset during M2 so it is abandoned.
    task automatic abort_cycle(input logic [7:0] inst);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clock);
            if (k == 3) data_in = inst[7:4];
            if (k == 4) data_in = inst[3:0];
        end
        #1 reset = 1'b1;
        @(negedge clock);
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        reset   = 1'b1;
        data_in = 4'h0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        //        addr     inst   {cc,ca,wa,ais,wr,ris}  operand
        run_cycle(12'h000, 8'hD7, 6'b001000, 4'h7);   // LDM 7
        run_cycle(12'h001, 8'hB3, 6'b001110, 4'h3);   // XCH r3
        run_cycle(12'h002, 8'h45, 6'b000000, 4'h5);   // JUN first word
        run_cycle(12'h003, 8'h6A, 6'b000000, 4'hA);   // JUN second word -> 0x56A
        run_cycle(12'h56A, 8'h4F, 6'b000000, 4'hF);   // JUN 0xFFF
        run_cycle(12'h56B, 8'hFF, 6'b000000, 4'hF);
        run_cycle(12'hFFF, 8'h40, 6'b000000, 4'h0);   // JUN first word at 0xFFF
        run_cycle(12'h000, 8'h12, 6'b000000, 4'h2);   // second word wraps to 0x000
        run_cycle(12'h012, 8'hF0, 6'b110000, 4'h0);   // CLB
        run_cycle(12'h013, 8'hF1, 6'b100000, 4'h1);   // CLC
        run_cycle(12'h014, 8'h20, 6'b000000, 4'h0);   // undefined -> NOP
        abort_cycle(8'hD5);                          // LDM at 0x015 abandoned
        run_cycle(12'h000, 8'hA9, 6'b001100, 4'h9);   // LD r9 after restart
        run_cycle(12'h001, 8'hFA, 6'b000000, 4'hA);   // group F, not CLB/CLC
        @(posedge clock);
        #1 done = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
